// File: rtl/dcm_prog_ctrl.sv
// Reprogramming sequencer for the dcm clk_2 divider select: debounced up/down buttons
// and a direct-load port become single update/prog_in transactions confirmed by prog_out.
module dcm_prog_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       load_req,
    input  logic [2:0] load_val,
    input  logic [2:0] dcm_prog_out,
    output logic       update,
    output logic [2:0] prog_in,
    output logic [2:0] cur_mode,
    output logic       busy,
    output logic       err
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK
    } state_t;

    state_t state, state_nxt;

    // Bit 0 is the up button, bit 1 the down button.
    logic [1:0]           btn_raw;
    logic [1:0]           sync1, sync2;
    logic [1:0]           deb, deb_d;
    logic [1:0][DB_W-1:0] db_cnt;
    logic [1:0]           press;
    logic                 up_evt, down_evt;

    logic       tgt_valid;
    logic [2:0] tgt;
    logic       start;
    logic       ack;
    logic       timeout;
    logic [TO_W-1:0] to_cnt;

    assign btn_raw = {btn_down, btn_up};

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            deb    <= '0;
            deb_d  <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press    = deb & ~deb_d;
    assign up_evt   = press[0];
    assign down_evt = press[1];

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        tgt_valid = 1'b0;
        tgt       = cur_mode;
        if (load_req) begin
            tgt_valid = 1'b1;
            tgt       = load_val;
        end else if (up_evt && !down_evt) begin
            tgt_valid = 1'b1;
            tgt       = (cur_mode == 3'd0) ? 3'd0 : cur_mode - 3'd1;
        end else if (down_evt && !up_evt) begin
            tgt_valid = 1'b1;
            tgt       = (cur_mode == 3'd7) ? 3'd7 : cur_mode + 3'd1;
        end
    end

    assign start   = tgt_valid && (tgt != cur_mode);
    assign ack     = (dcm_prog_out == prog_in);
    assign timeout = (to_cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = ISSUE;
            ISSUE:    state_nxt = WAIT_ACK;
            WAIT_ACK: if (ack || timeout) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            update   <= 1'b0;
            prog_in  <= 3'd0;
            cur_mode <= 3'd0;
            err      <= 1'b0;
            to_cnt   <= '0;
        end else begin
            // Registered so the pulse covers exactly the ISSUE cycle.
            update <= (state_nxt == ISSUE);
            case (state)
                IDLE: begin
                    if (start) prog_in <= tgt;
                end
                ISSUE: begin
                    to_cnt <= '0;
                end
                WAIT_ACK: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (ack) begin
                        cur_mode <= prog_in;
                        err      <= 1'b0;
                    end else if (timeout) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Directed bench for dcm_prog_ctrl with a small dcm model whose ack can be disabled.
module tb_dcm_prog_ctrl;

    localparam int DEBOUNCE = 4;
    localparam int TIMEOUT  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       load_req = 1'b0;
    logic [2:0] load_val = 3'd0;
    logic [2:0] dcm_out = 3'd0;
    logic       update;
    logic [2:0] prog_in;
    logic [2:0] cur_mode;
    logic       busy;
    logic       err;

    logic       ack_en = 1'b1;

    int         n_checks = 0;
    int         n_errors = 0;
    int         upd_cnt;
    int         busy_cyc;
    logic [2:0] last_upd;

    dcm_prog_ctrl #(
        .DEBOUNCE_CYCLES(DEBOUNCE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .load_req    (load_req),
        .load_val    (load_val),
        .dcm_prog_out(dcm_out),
        .update      (update),
        .prog_in     (prog_in),
        .cur_mode    (cur_mode),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    // dcm model: reflects prog_in on prog_out one cycle after an update pulse.
    always @(posedge clk) begin
        if (update && ack_en) dcm_out <= prog_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (update) begin
                upd_cnt++;
                last_upd = prog_in;
            end
            if (busy) busy_cyc++;
        end
    endtask

    task automatic clear_stats();
        upd_cnt  = 0;
        busy_cyc = 0;
        last_upd = 3'd0;
    endtask

    task automatic press(input bit is_up, input int hold);
        if (is_up) btn_up = 1'b1; else btn_down = 1'b1;
        step(hold);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        step(12);
    endtask

    task automatic load(input logic [2:0] v, input int settle);
        load_req = 1'b1;
        load_val = v;
        step(1);
        load_req = 1'b0;
        step(settle);
    endtask

    initial begin
        int n;
        clear_stats();

        // Reset values
        step(2);
        check("rst_update", update, 0);
        check("rst_prog_in", prog_in, 0);
        check("rst_cur_mode", cur_mode, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        step(2);

        // 1: clean down press, dcm acks
        clear_stats();
        press(1'b0, 12);
        check("t1_updates", upd_cnt, 1);
        check("t1_upd_val", last_upd, 1);
        check("t1_cur_mode", cur_mode, 1);
        check("t1_busy_le3", busy_cyc <= 3, 1);
        check("t1_err", err, 0);

        // 2: saturation at 0 and 7
        load(3'd0, 8);
        check("t2_load0_mode", cur_mode, 0);
        clear_stats();
        press(1'b1, 12);
        check("t2_up_at0_updates", upd_cnt, 0);
        check("t2_up_at0_mode", cur_mode, 0);
        clear_stats();
        load(3'd7, 8);
        press(1'b0, 12);
        press(1'b0, 12);
        check("t2_sat7_updates", upd_cnt, 1);
        check("t2_sat7_val", last_upd, 7);
        check("t2_sat7_mode", cur_mode, 7);

        // 3: short glitch ignored, bouncing press yields one event
        clear_stats();
        btn_up = 1'b1; step(DEBOUNCE - 1);
        btn_up = 1'b0; step(12);
        check("t3_glitch_updates", upd_cnt, 0);
        check("t3_glitch_mode", cur_mode, 7);
        btn_up = 1'b1; step(1);
        btn_up = 1'b0; step(1);
        btn_up = 1'b1; step(2);
        btn_up = 1'b0; step(1);
        press(1'b1, 12);
        check("t3_bounce_updates", upd_cnt, 1);
        check("t3_bounce_mode", cur_mode, 6);

        // 4: timeout without ack, then recovery
        ack_en = 1'b0;
        clear_stats();
        load_req = 1'b1;
        load_val = 3'd5;
        step(1);
        load_req = 1'b0;
        check("t4_update_pulse", update, 1);
        n = 0;
        while (!err && n < 40) begin
            step(1);
            n++;
        end
        // ISSUE cycle ends, then TIMEOUT cycles in WAIT_ACK before err rises.
        check("t4_err_delay", n, TIMEOUT + 1);
        check("t4_err", err, 1);
        check("t4_busy", busy, 0);
        check("t4_cur_mode", cur_mode, 6);
        check("t4_prog_in", prog_in, 5);
        step(4);
        check("t4_updates", upd_cnt, 1);
        ack_en = 1'b1;
        clear_stats();
        load(3'd3, 8);
        check("t4_recover_err", err, 0);
        check("t4_recover_mode", cur_mode, 3);
        check("t4_recover_updates", upd_cnt, 1);

        // 5: load beats a down event; press while busy dropped; up+down together ignored
        clear_stats();
        load_req = 1'b1;
        load_val = 3'd4;
        btn_down = 1'b1;
        step(12);
        load_req = 1'b0;
        btn_down = 1'b0;
        step(12);
        check("t5_prio_updates", upd_cnt, 1);
        check("t5_prio_val", last_upd, 4);
        check("t5_prio_mode", cur_mode, 4);

        ack_en = 1'b0;
        clear_stats();
        load_req = 1'b1;
        load_val = 3'd1;
        step(1);
        load_req = 1'b0;
        btn_up = 1'b1;
        step(12);
        btn_up = 1'b0;
        step(24);
        check("t5_busy_drop_updates", upd_cnt, 1);
        check("t5_busy_drop_err", err, 1);
        check("t5_busy_drop_mode", cur_mode, 4);
        ack_en = 1'b1;

        clear_stats();
        btn_up   = 1'b1;
        btn_down = 1'b1;
        step(12);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        step(12);
        check("t5_both_updates", upd_cnt, 0);
        check("t5_both_mode", cur_mode, 4);

        // 6: async reset in WAIT_ACK
        ack_en = 1'b0;
        load_req = 1'b1;
        load_val = 3'd2;
        step(1);
        load_req = 1'b0;
        step(3);
        check("t6_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_update", update, 0);
        check("t6_prog_in", prog_in, 0);
        check("t6_cur_mode", cur_mode, 0);
        check("t6_busy", busy, 0);
        check("t6_err", err, 0);
        clear_stats();
        step(3);
        #2 rst = 1'b0;
        step(3);
        check("t6_no_update", upd_cnt, 0);
        check("t6_idle", busy, 0);
        ack_en = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
